vc_pop_arbiter: RTL

- Read-side consumer for the VC0/VC1 virtual-channel FIFOs in the transmit path.
- Pops words from the FIFOs, giving VC0 strict priority, and routes each word to the D0 or D1 destination FIFO according to a destination bit in the word.
- Honours destination back-pressure through the almost_full and full flags.
- Uses the FIFO peek output (next word at the read pointer) to choose the destination before popping.

---
 rtl/vc_arb_pkg.sv | 19 +
 rtl/vc_grant_sel.sv | 61 ++++++
 rtl/vc_pop_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/vc_arb_pkg.sv
// Shared types and defaults for the VC0/VC1 pop arbiter and its grant selector.
// ARB_FAIRNESS_EN (see vc_grant_sel) is the only build-time option.
package vc_arb_pkg;

  localparam int DATA_WIDTH_DEF    = 6;
  localparam int DEST_BIT_DEF      = 4;
  localparam int MAX_VC0_BURST_DEF = 4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  typedef enum logic {
    SRC_VC0 = 1'b0,
    SRC_VC1 = 1'b1
  } src_t;

endpackage

// File: rtl/vc_grant_sel.sv
// Eligibility and priority between VC0 and VC1 for one pop per cycle.
// With ARB_FAIRNESS_EN defined, a VC0 burst counter periodically hands a grant to VC1.
module vc_grant_sel
  import vc_arb_pkg::*;
#(
  parameter int MAX_VC0_BURST = MAX_VC0_BURST_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_enable,
  input  logic i_empty_VC0,
  input  logic i_empty_VC1,
  input  logic i_dest_VC0,
  input  logic i_dest_VC1,
  input  logic i_almost_full_D0,
  input  logic i_almost_full_D1,
  input  logic i_full_D0,
  input  logic i_full_D1,
  output logic grant_VC0,
  output logic grant_VC1
);

  logic w_busy_D0;
  logic w_busy_D1;
  logic w_elig_VC0;
  logic w_elig_VC1;

  // almost_full alone closes a destination, which also covers holding off while a
  // pending word heads to a destination that is nearly full.
  assign w_busy_D0  = i_almost_full_D0 | i_full_D0;
  assign w_busy_D1  = i_almost_full_D1 | i_full_D1;
  assign w_elig_VC0 = i_enable & ~i_empty_VC0 & ~(i_dest_VC0 ? w_busy_D1 : w_busy_D0);
  assign w_elig_VC1 = i_enable & ~i_empty_VC1 & ~(i_dest_VC1 ? w_busy_D1 : w_busy_D0);

`ifdef ARB_FAIRNESS_EN
  logic [2:0] r_burst;
  logic       w_force_VC1;

  assign w_force_VC1 = (r_burst >= 3'(MAX_VC0_BURST)) & w_elig_VC1;
  assign grant_VC0   = w_elig_VC0 & ~w_force_VC1;
  assign grant_VC1   = w_elig_VC1 & ~grant_VC0;

  // Saturates at the limit so a VC0-only stretch cannot wrap back to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_burst <= 3'd0;
    end else if (grant_VC1) begin
      r_burst <= 3'd0;
    end else if (grant_VC0 && (r_burst < 3'(MAX_VC0_BURST))) begin
      r_burst <= r_burst + 3'd1;
    end
  end
`else
  logic w_unused;

  assign grant_VC0 = w_elig_VC0;
  assign grant_VC1 = w_elig_VC1 & ~w_elig_VC0;
  assign w_unused  = &{1'b0, clk, reset};
`endif

endmodule

// File: rtl/vc_pop_arbiter.sv
// Pops VC0/VC1 FIFOs and routes each word to D0/D1 by its destination bit, two cycles pop-to-push.
// Optional ARB_FAIRNESS_EN bounds consecutive VC0 grants (implemented in vc_grant_sel).
module vc_pop_arbiter
  import vc_arb_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int DEST_BIT      = DEST_BIT_DEF,
  parameter int MAX_VC0_BURST = MAX_VC0_BURST_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic                  empty_VC0,
  input  logic                  empty_VC1,
  input  logic [DATA_WIDTH-1:0] peek_VC0,
  input  logic [DATA_WIDTH-1:0] peek_VC1,
  input  logic [DATA_WIDTH-1:0] data_VC0,
  input  logic [DATA_WIDTH-1:0] data_VC1,
  input  logic                  almost_full_D0,
  input  logic                  almost_full_D1,
  input  logic                  full_D0,
  input  logic                  full_D1,
  output logic                  pop_VC0,
  output logic                  pop_VC1,
  output logic                  push_D0,
  output logic                  push_D1,
  output logic [DATA_WIDTH-1:0] data_out_D0,
  output logic [DATA_WIDTH-1:0] data_out_D1,
  output logic                  active,
  output logic                  error
);

  state_t                r_state;
  logic                  r_pending;
  src_t                  r_src;
  logic                  r_dest;
  logic                  r_push_D0;
  logic                  r_push_D1;
  logic [DATA_WIDTH-1:0] r_data_D0;
  logic [DATA_WIDTH-1:0] r_data_D1;
  logic                  r_error;

  logic                  w_enable;
  logic                  w_grant_VC0;
  logic                  w_grant_VC1;
  logic [DATA_WIDTH-1:0] w_captured;
  logic                  w_unused;

  // Pops are combinational so the peek word and the pop refer to the same FIFO entry.
  assign w_enable = (r_state == ST_ACTIVE) & init & ~reset;

  vc_grant_sel #(
    .MAX_VC0_BURST (MAX_VC0_BURST)
  ) u_grant_sel (
    .clk              (clk),
    .reset            (reset),
    .i_enable         (w_enable),
    .i_empty_VC0      (empty_VC0),
    .i_empty_VC1      (empty_VC1),
    .i_dest_VC0       (peek_VC0[DEST_BIT]),
    .i_dest_VC1       (peek_VC1[DEST_BIT]),
    .i_almost_full_D0 (almost_full_D0),
    .i_almost_full_D1 (almost_full_D1),
    .i_full_D0        (full_D0),
    .i_full_D1        (full_D1),
    .grant_VC0        (w_grant_VC0),
    .grant_VC1        (w_grant_VC1)
  );

  assign w_captured = (r_src == SRC_VC1) ? data_VC1 : data_VC0;
  assign w_unused   = &{1'b0, peek_VC0, peek_VC1};

  // FSM plus the two pipeline stages; the pipeline drains even after leaving ACTIVE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_pending <= 1'b0;
      r_src     <= SRC_VC0;
      r_dest    <= 1'b0;
      r_push_D0 <= 1'b0;
      r_push_D1 <= 1'b0;
      r_data_D0 <= '0;
      r_data_D1 <= '0;
      r_error   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE:   if (init && (!empty_VC0 || !empty_VC1)) r_state <= ST_ACTIVE;
        ST_ACTIVE: if (!init || (empty_VC0 && empty_VC1 && !r_pending)) r_state <= ST_IDLE;
      endcase

      r_pending <= w_grant_VC0 | w_grant_VC1;
      if (w_grant_VC0 || w_grant_VC1) begin
        r_src  <= w_grant_VC1 ? SRC_VC1 : SRC_VC0;
        r_dest <= w_grant_VC1 ? peek_VC1[DEST_BIT] : peek_VC0[DEST_BIT];
      end

      r_push_D0 <= r_pending & ~r_dest;
      r_push_D1 <= r_pending & r_dest;
      if (r_pending && !r_dest) r_data_D0 <= w_captured;
      if (r_pending && r_dest)  r_data_D1 <= w_captured;

      // The push still goes out into a full FIFO; the loss is recorded instead.
      if ((r_push_D0 && full_D0) || (r_push_D1 && full_D1)) r_error <= 1'b1;
    end
  end

  assign pop_VC0     = w_grant_VC0;
  assign pop_VC1     = w_grant_VC1;
  assign push_D0     = r_push_D0;
  assign push_D1     = r_push_D1;
  assign data_out_D0 = r_data_D0;
  assign data_out_D1 = r_data_D1;
  assign active      = (r_state == ST_ACTIVE);
  assign error       = r_error;

endmodule
